// File: rtl/dcache_assoc.sv
// dcache_assoc: 2-way set-associative, write-back / write-allocate data cache.
//
// Sits between the CPU memory stage and a word-burst DRAM port. Hits are
// serviced in IDLE: reads return data one cycle later, writes merge under
// byte_en. A miss latches the request and picks a victim (first invalid
// way, way0 preferred, otherwise the LRU way). A dirty victim is copied to a
// write-back buffer and burst out (WB). The missing block is then burst in
// (FILL) and installed in a single cycle (UPDATE). The CPU is stalled through
// ram_abort and replays the access, which then hits.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   cpu_addr, data_req, wren   CPU byte address ([1:0] ignored), request, write
//   byte_en, cpu_wr_data       write lanes and write data
//   cpu_rd_data                registered read word (holds without a read hit)
//   hit, ram_abort             combinational hit, CPU stall
//   dram_wr_*                  victim write-back burst (req/addr/data out, val in)
//   dram_rd_*                  fill burst (req/addr out, data/val in)
//   stat_hits/misses/wbacks    statistics counters
//
// Optional build macro DCACHE_STATS_EN: when defined, the three stat_* outputs
// are 32-bit wrapping counters. When undefined, they are tied to zero.
module dcache_assoc #(
    parameter int INDEX_W  = 8,
    parameter int OFFSET_W = 3,
    localparam int TAG_W   = 32 - INDEX_W - OFFSET_W - 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] cpu_addr,
    input  logic        data_req,
    input  logic        wren,
    input  logic [3:0]  byte_en,
    input  logic [31:0] cpu_wr_data,
    output logic [31:0] cpu_rd_data,
    output logic        hit,
    output logic        ram_abort,
    output logic        dram_wr_req,
    output logic [31:0] dram_wr_addr,
    output logic [31:0] dram_wr_data,
    input  logic        dram_wr_val,
    output logic        dram_rd_req,
    output logic [31:0] dram_rd_addr,
    input  logic [31:0] dram_rd_data,
    input  logic        dram_rd_val,
    output logic [31:0] stat_hits,
    output logic [31:0] stat_misses,
    output logic [31:0] stat_wbacks
);
    localparam int SETS  = 2 ** INDEX_W;
    localparam int WORDS = 2 ** OFFSET_W;
    localparam logic [OFFSET_W-1:0] CNT_LAST = {OFFSET_W{1'b1}};
    localparam logic [OFFSET_W-1:0] CNT_ZERO = {OFFSET_W{1'b0}};
    localparam logic [OFFSET_W-1:0] CNT_ONE  = {{(OFFSET_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WB     = 2'd1,
        ST_FILL   = 2'd2,
        ST_UPDATE = 2'd3
    } state_t;

    // Byte-lane merge: lanes selected in be take new_w, others keep old_w.
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                                input logic [31:0] new_w,
                                                input logic [3:0]  be);
        logic [31:0] res;
        res = old_w;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) begin
                res[8*b +: 8] = new_w[8*b +: 8];
            end
        end
        return res;
    endfunction

    state_t state_r, next_state_s;

    logic [TAG_W-1:0] tag_mem_r  [0:1][0:SETS-1];
    logic [31:0]      data_mem_r [0:1][0:SETS-1][0:WORDS-1];
    logic [SETS-1:0]  valid_r    [0:1];
    logic [SETS-1:0]  dirty_r    [0:1];
    logic [SETS-1:0]  lru_r;

    logic [31:0]         wb_buf_r   [0:WORDS-1];
    logic [31:0]         fill_buf_r [0:WORDS-1];
    logic [OFFSET_W-1:0] wr_cnt_r, rd_cnt_r;

    logic [TAG_W-1:0]    miss_tag_r, victim_tag_r;
    logic [INDEX_W-1:0]  miss_index_r;
    logic [OFFSET_W-1:0] miss_word_r;
    logic                miss_wren_r, victim_way_r;
    logic [3:0]          miss_be_r;
    logic [31:0]         miss_data_r;

    logic [TAG_W-1:0]    addr_tag_s;
    logic [INDEX_W-1:0]  addr_index_s;
    logic [OFFSET_W-1:0] addr_word_s;
    logic hit0_s, hit1_s, hit_any_s, hit_way_s;
    logic acc_hit_s, miss_s, victim_way_s, victim_dirty_s;
    logic unused_addr_s;

    assign addr_tag_s    = cpu_addr[31 -: TAG_W];
    assign addr_index_s  = cpu_addr[OFFSET_W+2 +: INDEX_W];
    assign addr_word_s   = cpu_addr[2 +: OFFSET_W];
    assign unused_addr_s = ^cpu_addr[1:0];

    assign hit0_s    = valid_r[0][addr_index_s] && (tag_mem_r[0][addr_index_s] == addr_tag_s);
    assign hit1_s    = valid_r[1][addr_index_s] && (tag_mem_r[1][addr_index_s] == addr_tag_s);
    assign hit_any_s = hit0_s | hit1_s;
    assign hit_way_s = hit1_s;
    assign hit       = data_req & hit_any_s;
    assign acc_hit_s = (state_r == ST_IDLE) & hit;
    assign miss_s    = (state_r == ST_IDLE) & data_req & ~hit_any_s;

    // Victim choice: first invalid way (way0 preferred), else the LRU way.
    always_comb begin
        victim_way_s = 1'b0;
        if (!valid_r[0][addr_index_s]) begin
            victim_way_s = 1'b0;
        end else if (!valid_r[1][addr_index_s]) begin
            victim_way_s = 1'b1;
        end else begin
            victim_way_s = lru_r[addr_index_s];
        end
    end
    assign victim_dirty_s = valid_r[victim_way_s][addr_index_s] & dirty_r[victim_way_s][addr_index_s];

    // Next-state logic; a val pulse only counts in the state it arrives in.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (miss_s) begin
                    next_state_s = victim_dirty_s ? ST_WB : ST_FILL;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_WB: begin
                if (dram_wr_val && (wr_cnt_r == CNT_LAST)) begin
                    next_state_s = ST_FILL;
                end else begin
                    next_state_s = ST_WB;
                end
            end
            ST_FILL: begin
                if (dram_rd_val && (rd_cnt_r == CNT_LAST)) begin
                    next_state_s = ST_UPDATE;
                end else begin
                    next_state_s = ST_FILL;
                end
            end
            ST_UPDATE: next_state_s = ST_IDLE;
            default:   next_state_s = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Line metadata, burst counters, miss latches and the read-data register.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_r[0]   <= {SETS{1'b0}};
            valid_r[1]   <= {SETS{1'b0}};
            dirty_r[0]   <= {SETS{1'b0}};
            dirty_r[1]   <= {SETS{1'b0}};
            lru_r        <= {SETS{1'b0}};
            wr_cnt_r     <= CNT_ZERO;
            rd_cnt_r     <= CNT_ZERO;
            cpu_rd_data  <= 32'd0;
            miss_tag_r   <= {TAG_W{1'b0}};
            victim_tag_r <= {TAG_W{1'b0}};
            miss_index_r <= {INDEX_W{1'b0}};
            miss_word_r  <= CNT_ZERO;
            miss_wren_r  <= 1'b0;
            victim_way_r <= 1'b0;
            miss_be_r    <= 4'd0;
            miss_data_r  <= 32'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (acc_hit_s) begin
                        lru_r[addr_index_s] <= ~hit_way_s;
                        if (wren) begin
                            // An all-zero byte_en write only touches LRU.
                            if (|byte_en) begin
                                dirty_r[hit_way_s][addr_index_s] <= 1'b1;
                            end
                        end else begin
                            cpu_rd_data <= data_mem_r[hit_way_s][addr_index_s][addr_word_s];
                        end
                    end else if (miss_s) begin
                        miss_tag_r   <= addr_tag_s;
                        miss_index_r <= addr_index_s;
                        miss_word_r  <= addr_word_s;
                        miss_wren_r  <= wren;
                        miss_be_r    <= byte_en;
                        miss_data_r  <= cpu_wr_data;
                        victim_way_r <= victim_way_s;
                        victim_tag_r <= tag_mem_r[victim_way_s][addr_index_s];
                    end
                end
                ST_WB: begin
                    if (dram_wr_val) begin
                        wr_cnt_r <= (wr_cnt_r == CNT_LAST) ? CNT_ZERO : wr_cnt_r + CNT_ONE;
                    end
                end
                ST_FILL: begin
                    if (dram_rd_val) begin
                        rd_cnt_r <= (rd_cnt_r == CNT_LAST) ? CNT_ZERO : rd_cnt_r + CNT_ONE;
                    end
                end
                ST_UPDATE: begin
                    valid_r[victim_way_r][miss_index_r] <= 1'b1;
                    dirty_r[victim_way_r][miss_index_r] <= miss_wren_r;
                    lru_r[miss_index_r]                 <= ~victim_way_r;
                end
                default: ;
            endcase
        end
    end

    // Data/tag arrays and burst buffers (no reset: validity lives in valid_r).
    always_ff @(posedge clk) begin
        if (!reset) begin
            case (state_r)
                ST_IDLE: begin
                    if (acc_hit_s && wren) begin
                        data_mem_r[hit_way_s][addr_index_s][addr_word_s] <=
                            merge_bytes(data_mem_r[hit_way_s][addr_index_s][addr_word_s], cpu_wr_data, byte_en);
                    end else if (miss_s) begin
                        for (int w = 0; w < WORDS; w++) begin
                            wb_buf_r[w] <= data_mem_r[victim_way_s][addr_index_s][w];
                        end
                    end
                end
                ST_FILL: begin
                    if (dram_rd_val) begin
                        fill_buf_r[rd_cnt_r] <= dram_rd_data;
                    end
                end
                ST_UPDATE: begin
                    tag_mem_r[victim_way_r][miss_index_r] <= miss_tag_r;
                    for (int w = 0; w < WORDS; w++) begin
                        data_mem_r[victim_way_r][miss_index_r][w] <=
                            (miss_wren_r && (OFFSET_W'(w) == miss_word_r))
                            ? merge_bytes(fill_buf_r[w], miss_data_r, miss_be_r)
                            : fill_buf_r[w];
                    end
                end
                default: ;
            endcase
        end
    end

    assign dram_wr_req  = (state_r == ST_WB);
    assign dram_rd_req  = (state_r == ST_FILL);
    assign dram_wr_addr = {victim_tag_r, miss_index_r, {(OFFSET_W+2){1'b0}}};
    assign dram_rd_addr = {miss_tag_r, miss_index_r, {(OFFSET_W+2){1'b0}}};
    assign dram_wr_data = wb_buf_r[wr_cnt_r];
    assign ram_abort    = (state_r != ST_IDLE) | (data_req & ~hit_any_s);

`ifdef DCACHE_STATS_EN
    logic [31:0] stat_hits_r, stat_misses_r, stat_wbacks_r;

    // Event counters: IDLE hits, misses leaving IDLE, write-backs completed.
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_hits_r   <= 32'd0;
            stat_misses_r <= 32'd0;
            stat_wbacks_r <= 32'd0;
        end else begin
            if (acc_hit_s) begin
                stat_hits_r <= stat_hits_r + 32'd1;
            end
            if ((state_r == ST_IDLE) && (next_state_s != ST_IDLE)) begin
                stat_misses_r <= stat_misses_r + 32'd1;
            end
            if ((state_r == ST_WB) && (next_state_s == ST_FILL)) begin
                stat_wbacks_r <= stat_wbacks_r + 32'd1;
            end
        end
    end
    assign stat_hits   = stat_hits_r;
    assign stat_misses = stat_misses_r;
    assign stat_wbacks = stat_wbacks_r;
`else
    assign stat_hits   = 32'd0;
    assign stat_misses = 32'd0;
    assign stat_wbacks = 32'd0;
`endif

endmodule

// File: tb/tb_dcache_assoc.sv
// Directed testbench for dcache_assoc (default geometry: 256 sets, 8 words).
// Address map: tag = [31:13], index = [12:5], word = [4:2].
// 0x1000, 0x3000 and 0x5000 share index 0x80 with tags 0, 1 and 2.
// Stat counter checks follow DCACHE_STATS_EN.
`timescale 1ns/1ps
module tb_dcache_assoc;
    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] cpu_addr;
    logic        data_req;
    logic        wren;
    logic [3:0]  byte_en;
    logic [31:0] cpu_wr_data;
    logic [31:0] cpu_rd_data;
    logic        hit;
    logic        ram_abort;
    logic        dram_wr_req;
    logic [31:0] dram_wr_addr;
    logic [31:0] dram_wr_data;
    logic        dram_wr_val;
    logic        dram_rd_req;
    logic [31:0] dram_rd_addr;
    logic [31:0] dram_rd_data;
    logic        dram_rd_val;
    logic [31:0] stat_hits, stat_misses, stat_wbacks;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dcache_assoc dut (
        .clk(clk), .reset(reset), .cpu_addr(cpu_addr), .data_req(data_req),
        .wren(wren), .byte_en(byte_en), .cpu_wr_data(cpu_wr_data),
        .cpu_rd_data(cpu_rd_data), .hit(hit), .ram_abort(ram_abort),
        .dram_wr_req(dram_wr_req), .dram_wr_addr(dram_wr_addr),
        .dram_wr_data(dram_wr_data), .dram_wr_val(dram_wr_val),
        .dram_rd_req(dram_rd_req), .dram_rd_addr(dram_rd_addr),
        .dram_rd_data(dram_rd_data), .dram_rd_val(dram_rd_val),
        .stat_hits(stat_hits), .stat_misses(stat_misses), .stat_wbacks(stat_wbacks)
    );

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a CPU access and let combinational outputs settle.
    task automatic cpu_access(input logic [31:0] a, input logic w, input logic [3:0] be, input logic [31:0] d);
        data_req    = 1'b1;
        cpu_addr    = a;
        wren        = w;
        byte_en     = be;
        cpu_wr_data = d;
        #1;
    endtask

    // Act as DRAM for one fill burst of words base+0..base+7 with random gaps.
    // bad counts cycles where the request or the stall was not held.
    task automatic serve_fill(input logic [31:0] base, input int gap_max, output int bad);
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            repeat ($urandom_range(gap_max, 0)) begin
                if (dram_rd_req !== 1'b1 || ram_abort !== 1'b1) bad++;
                tick();
            end
            dram_rd_val  = 1'b1;
            dram_rd_data = base + 32'(i);
            #1;
            if (dram_rd_req !== 1'b1 || ram_abort !== 1'b1) bad++;
            tick();
            dram_rd_val = 1'b0;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; data_req = 1'b0; wren = 1'b0; byte_en = 4'd0;
        cpu_addr = 32'd0; cpu_wr_data = 32'd0;
        dram_wr_val = 1'b0; dram_rd_val = 1'b0; dram_rd_data = 32'd0;
        repeat (3) tick();
        reset = 1'b0;
        #1;
        checks++; if (cpu_rd_data !== 32'd0) begin errors++; $display("FAIL reset_rd_data: got %h want %h", cpu_rd_data, 32'd0); end
        checks++; if (dram_rd_req !== 1'b0 || dram_wr_req !== 1'b0) begin errors++; $display("FAIL reset_reqs: got rd=%b wr=%b want 0 0", dram_rd_req, dram_wr_req); end
        checks++; if (ram_abort !== 1'b0) begin errors++; $display("FAIL reset_abort: got %b want 0", ram_abort); end
        checks++; if (stat_hits !== 32'd0 || stat_misses !== 32'd0 || stat_wbacks !== 32'd0) begin errors++; $display("FAIL reset_stats: got %0d %0d %0d want 0 0 0", stat_hits, stat_misses, stat_wbacks); end
    endtask

    task automatic test_cold_read();
        int bad;
        cpu_access(32'h0000_1004, 1'b0, 4'd0, 32'd0);
        checks++; if (hit !== 1'b0 || ram_abort !== 1'b1) begin errors++; $display("FAIL cold_miss: got hit=%b abort=%b want 0 1", hit, ram_abort); end
        tick();
        checks++; if (dram_rd_req !== 1'b1 || dram_wr_req !== 1'b0) begin errors++; $display("FAIL cold_fill_req: got rd=%b wr=%b want 1 0", dram_rd_req, dram_wr_req); end
        checks++; if (dram_rd_addr !== 32'h0000_1000) begin errors++; $display("FAIL cold_rd_addr: got %h want %h", dram_rd_addr, 32'h0000_1000); end
        serve_fill(32'hA0, 0, bad);
        checks++; if (bad !== 0) begin errors++; $display("FAIL cold_burst_hold: got %0d bad cycles want 0", bad); end
        checks++; if (hit !== 1'b0 || ram_abort !== 1'b1) begin errors++; $display("FAIL cold_update: got hit=%b abort=%b want 0 1", hit, ram_abort); end
        tick();
        checks++; if (hit !== 1'b1 || ram_abort !== 1'b0 || dram_rd_req !== 1'b0) begin errors++; $display("FAIL cold_replay: got hit=%b abort=%b rd=%b want 1 0 0", hit, ram_abort, dram_rd_req); end
        tick();
        checks++; if (cpu_rd_data !== 32'hA1) begin errors++; $display("FAIL cold_rd_data: got %h want %h", cpu_rd_data, 32'hA1); end
`ifdef DCACHE_STATS_EN
        checks++; if (stat_misses !== 32'd1) begin errors++; $display("FAIL cold_stat_misses: got %0d want 1", stat_misses); end
`endif
        data_req = 1'b0;
    endtask

    task automatic test_write_hit();
        cpu_access(32'h0000_1008, 1'b1, 4'b0101, 32'h1122_3344);
        checks++; if (hit !== 1'b1 || ram_abort !== 1'b0) begin errors++; $display("FAIL wr_hit: got hit=%b abort=%b want 1 0", hit, ram_abort); end
        tick();
        checks++; if (dram_rd_req !== 1'b0 || dram_wr_req !== 1'b0) begin errors++; $display("FAIL wr_no_dram: got rd=%b wr=%b want 0 0", dram_rd_req, dram_wr_req); end
        checks++; if (cpu_rd_data !== 32'hA1) begin errors++; $display("FAIL wr_rd_hold: got %h want %h", cpu_rd_data, 32'hA1); end
        cpu_access(32'h0000_1008, 1'b1, 4'b0000, 32'hFFFF_FFFF);
        tick();
        cpu_access(32'h0000_1008, 1'b0, 4'd0, 32'd0);
        tick();
        checks++; if (cpu_rd_data !== 32'h0022_0044) begin errors++; $display("FAIL wr_merge: got %h want %h", cpu_rd_data, 32'h0022_0044); end
        data_req = 1'b0;
    endtask

    task automatic test_lru();
        int bad;
        cpu_access(32'h0000_3000, 1'b0, 4'd0, 32'd0);
        tick();
        checks++; if (dram_rd_req !== 1'b1 || dram_wr_req !== 1'b0 || dram_rd_addr !== 32'h0000_3000) begin errors++; $display("FAIL lru_t2_fill: got rd=%b wr=%b addr=%h want 1 0 00003000", dram_rd_req, dram_wr_req, dram_rd_addr); end
        serve_fill(32'hB0, 2, bad);
        tick(); tick();
        checks++; if (cpu_rd_data !== 32'hB0) begin errors++; $display("FAIL lru_t2_read: got %h want %h", cpu_rd_data, 32'hB0); end
        cpu_access(32'h0000_1008, 1'b0, 4'd0, 32'd0);
        tick();
        checks++; if (cpu_rd_data !== 32'h0022_0044) begin errors++; $display("FAIL lru_t1_read: got %h want %h", cpu_rd_data, 32'h0022_0044); end
        cpu_access(32'h0000_5004, 1'b0, 4'd0, 32'd0);
        tick();
        checks++; if (dram_wr_req !== 1'b0 || dram_rd_req !== 1'b1 || dram_rd_addr !== 32'h0000_5000) begin errors++; $display("FAIL lru_t3_clean_evict: got wr=%b rd=%b addr=%h want 0 1 00005000", dram_wr_req, dram_rd_req, dram_rd_addr); end
        serve_fill(32'hD0, 3, bad);
        checks++; if (bad !== 0) begin errors++; $display("FAIL lru_burst_hold: got %0d bad cycles want 0", bad); end
        tick(); tick();
        checks++; if (cpu_rd_data !== 32'hD1) begin errors++; $display("FAIL lru_t3_read: got %h want %h", cpu_rd_data, 32'hD1); end
        cpu_access(32'h0000_3000, 1'b0, 4'd0, 32'd0);
        checks++; if (hit !== 1'b0) begin errors++; $display("FAIL lru_t2_evicted: got hit=%b want 0", hit); end
        cpu_access(32'h0000_1008, 1'b0, 4'd0, 32'd0);
        checks++; if (hit !== 1'b1) begin errors++; $display("FAIL lru_t1_kept: got hit=%b want 1", hit); end
        tick();
        checks++; if (cpu_rd_data !== 32'h0022_0044) begin errors++; $display("FAIL lru_t1_data: got %h want %h", cpu_rd_data, 32'h0022_0044); end
        data_req = 1'b0;
    endtask

    task automatic test_dirty_evict();
        int bad;
        logic [31:0] exp_wb [8];
        for (int i = 0; i < 8; i++) exp_wb[i] = 32'hA0 + 32'(i);
        exp_wb[2] = 32'h0022_0044;
        // Touch T3 so that way0 (dirty T1) becomes the LRU way.
        cpu_access(32'h0000_5000, 1'b0, 4'd0, 32'd0);
        tick();
        cpu_access(32'h0000_3004, 1'b0, 4'd0, 32'd0);
        tick();
        checks++; if (dram_wr_req !== 1'b1 || dram_rd_req !== 1'b0 || dram_wr_addr !== 32'h0000_1000) begin errors++; $display("FAIL wb_start: got wr=%b rd=%b addr=%h want 1 0 00001000", dram_wr_req, dram_rd_req, dram_wr_addr); end
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            repeat ($urandom_range(3, 0)) begin
                if (dram_wr_req !== 1'b1 || ram_abort !== 1'b1) bad++;
                tick();
            end
            dram_wr_val = 1'b1;
            #1;
            checks++; if (dram_wr_data !== exp_wb[i]) begin errors++; $display("FAIL wb_word%0d: got %h want %h", i, dram_wr_data, exp_wb[i]); end
            tick();
            dram_wr_val = 1'b0;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL wb_burst_hold: got %0d bad cycles want 0", bad); end
        checks++; if (dram_wr_req !== 1'b0 || dram_rd_req !== 1'b1 || dram_rd_addr !== 32'h0000_3000) begin errors++; $display("FAIL wb_to_fill: got wr=%b rd=%b addr=%h want 0 1 00003000", dram_wr_req, dram_rd_req, dram_rd_addr); end
`ifdef DCACHE_STATS_EN
        checks++; if (stat_wbacks !== 32'd1 || stat_misses !== 32'd4) begin errors++; $display("FAIL wb_stats: got wbacks=%0d misses=%0d want 1 4", stat_wbacks, stat_misses); end
`endif
        serve_fill(32'hC0, 3, bad);
        checks++; if (bad !== 0) begin errors++; $display("FAIL wb_fill_hold: got %0d bad cycles want 0", bad); end
        tick(); tick();
        checks++; if (cpu_rd_data !== 32'hC1) begin errors++; $display("FAIL wb_replay_data: got %h want %h", cpu_rd_data, 32'hC1); end
        cpu_access(32'h0000_1000, 1'b0, 4'd0, 32'd0);
        checks++; if (hit !== 1'b0) begin errors++; $display("FAIL wb_t1_gone: got hit=%b want 0", hit); end
        data_req = 1'b0;
    endtask

    task automatic test_reset_mid_fill();
        int bad;
        cpu_access(32'h0000_0024, 1'b0, 4'd0, 32'd0);
        tick();
        checks++; if (dram_rd_req !== 1'b1 || dram_rd_addr !== 32'h0000_0020) begin errors++; $display("FAIL rst_fill_start: got rd=%b addr=%h want 1 00000020", dram_rd_req, dram_rd_addr); end
        for (int i = 0; i < 3; i++) begin
            dram_rd_val  = 1'b1;
            dram_rd_data = 32'hE0 + 32'(i);
            tick();
        end
        dram_rd_val = 1'b0;
        data_req    = 1'b0;
        reset       = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        checks++; if (dram_rd_req !== 1'b0 || ram_abort !== 1'b0) begin errors++; $display("FAIL rst_abort_burst: got rd=%b abort=%b want 0 0", dram_rd_req, ram_abort); end
        checks++; if (cpu_rd_data !== 32'd0 || stat_misses !== 32'd0) begin errors++; $display("FAIL rst_regs: got rd_data=%h misses=%0d want 0 0", cpu_rd_data, stat_misses); end
        cpu_access(32'h0000_3004, 1'b0, 4'd0, 32'd0);
        checks++; if (hit !== 1'b0) begin errors++; $display("FAIL rst_valid_cleared: got hit=%b want 0", hit); end
        cpu_access(32'h0000_0024, 1'b0, 4'd0, 32'd0);
        checks++; if (hit !== 1'b0 || ram_abort !== 1'b1) begin errors++; $display("FAIL rst_remiss: got hit=%b abort=%b want 0 1", hit, ram_abort); end
        tick();
        checks++; if (dram_rd_req !== 1'b1 || dram_rd_addr !== 32'h0000_0020) begin errors++; $display("FAIL rst_refill_start: got rd=%b addr=%h want 1 00000020", dram_rd_req, dram_rd_addr); end
        serve_fill(32'hF0, 1, bad);
        tick(); tick();
        checks++; if (cpu_rd_data !== 32'hF1) begin errors++; $display("FAIL rst_refill_data: got %h want %h", cpu_rd_data, 32'hF1); end
        data_req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_cold_read();
        test_write_hit();
        test_lru();
        test_dirty_evict();
        test_reset_mid_fill();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/dcache_assoc.md
Name: dcache_assoc

Overview:
- Parametrised 2-way set-associative, write-back + write-allocate data cache; successor to the direct-mapped 16KB dcache.
- Sits between the CPU memory stage and the DRAM word-burst port.
- Generalised in index/block size; adds per-byte write enables, true-LRU replacement, victim write-back buffering and optional statistics counters.

Parameters:
- INDEX_W, 8, set index bits; SETS = 2**INDEX_W.
- OFFSET_W, 3, word-offset bits; WORDS = 2**OFFSET_W words per block.
- TAG_W, 32-INDEX_W-OFFSET_W-2, tag bits (derived, not overridden).

Ports:
- clk  in  1  cache clock, same as CPU.
- reset  in  1  synchronous active-high reset.
- cpu_addr  in  32  byte address; [1:0] ignored.
- data_req  in  1  access request.
- wren  in  1  1 = write, 0 = read.
- byte_en  in  4  write byte lanes; bit i covers [8i+7:8i].
- cpu_wr_data  in  32  write data.
- cpu_rd_data  out  32  read word, registered.
- hit  out  1  combinational hit on current cpu_addr.
- ram_abort  out  1  stall the CPU.
- dram_wr_req  out  1  burst write request.
- dram_wr_addr  out  32  block-aligned byte address of victim.
- dram_wr_data  out  32  current write-back word.
- dram_wr_val  in  1  DRAM accepted one word.
- dram_rd_req  out  1  burst read request.
- dram_rd_addr  out  32  block-aligned byte address of miss.
- dram_rd_data  in  32  fill word.
- dram_rd_val  in  1  fill word valid.
- stat_hits, stat_misses, stat_wbacks  out  32 each  statistics (see Optional Feature).

Behaviour:
- Clocking and reset: clock clk; reset is synchronous, active-high.
- Reset clears all valid, dirty and LRU bits, word counters, FSM state and cpu_rd_data, and deasserts all requests. Reset mid-burst aborts the burst: requests drop the cycle after reset, and no partial fill is installed.
- Per-way line format: {valid, dirty, tag, WORDS*32 data}. One LRU bit per set; the bit names the way to evict.
- Hit: hit = data_req & (way0 valid & tag match | way1 valid & tag match). Both ways matching cannot occur.
- Read hit: the addressed word is latched into cpu_rd_data at the next edge (1-cycle latency). The LRU bit points to the other way.
- Write hit: only the lanes set in byte_en are updated at the edge, and the line's dirty bit is set. LRU is updated. byte_en = 0 updates LRU only.
- Miss (data_req & ~hit in IDLE):
  - Latch addr, wren, byte_en and wr_data.
  - Victim selection: first invalid way, with way0 preferred; otherwise the LRU way. Latch the victim way and tag.
  - Next state is WB if the victim is valid & dirty, else FILL.
- FSM states and transitions:
  - IDLE: accept hits and misses.
  - WB: on entry, copy the victim block into the write-back buffer. dram_wr_req=1. dram_wr_data = buf[wr_cnt] (combinational mux). wr_cnt advances on dram_wr_val. After the WORDS-th accepted word, wr_cnt clears and the next state is FILL.
  - FILL: dram_rd_req=1. On each dram_rd_val, dram_rd_data is written to fill word rd_cnt (ascending address order) and rd_cnt advances. After the WORDS-th word, rd_cnt clears and the next state is UPDATE.
  - UPDATE (1 cycle): install the fill block in the victim way with valid=1 and tag = miss tag. If the miss was a write, merge the latched data under the latched byte_en and set dirty=1; otherwise dirty=0. Set LRU to the other way. Next state is IDLE; the CPU replays the access and it hits.
- Addresses: dram_wr_addr = {victim tag, index, (OFFSET_W+2)'b0}. dram_rd_addr = {miss tag, index, zeros}. Both are stable for the whole burst.
- dram_rd_val/dram_wr_val outside FILL/WB are ignored. A val in the same cycle as a state change counts only in the current state.
- ram_abort = (state != IDLE) | (data_req & ~hit).
- cpu_rd_data holds its value when there is no read hit.

Optional Feature:
- Macro DCACHE_STATS_EN.
- Defined: stat_hits increments on each IDLE-state hit access. stat_misses increments on each IDLE→WB/FILL transition. stat_wbacks increments on each WB→FILL transition. All three are 32-bit wrapping counters, cleared by reset.
- Undefined: the ports remain and are tied to 0; no counter logic.

Test Plan:
- Cold read 0x0000_1004 → miss, no WB; dram_rd_addr=0x0000_1000, 8 fill words 0xA0..0xA7; after UPDATE the replay hits; cpu_rd_data=0xA1 one cycle later.
- Write hit 0x0000_1008, byte_en=4'b0101, data=0x1122_3344 over 0xA2 → word 0x0022_0044, dirty=1, no DRAM traffic.
- Same set, tags T1, T2 filled, then read T1 → third tag T3 evicts T2 (LRU) with no WB since T2 is clean; a subsequent T1 read still hits.
- Dirty victim evict → WB burst with dram_wr_addr = victim block address and dram_wr_data sequence equal to the stored words, then FILL; stat_wbacks=1 with DCACHE_STATS_EN.
- dram_wr_val/dram_rd_val with random gaps (0–3 idle cycles) → same final contents; ram_abort high throughout.
- Reset asserted after 3 fill words → next cycle dram_rd_req=0, state IDLE, a read of the same address misses again.
